// File: rtl/stopwatch_ctrl_if.sv
// Key inputs and sequencer controls for the stopwatch control block.
// The master side owns the buttons; the slave side is the sequencer.
interface stopwatch_ctrl_if;
  logic       key_start_n;
  logic       key_lap_n;
  logic       key_clr_n;
  logic       count_en;
  logic       count_clr;
  logic       lap_load;
  logic       disp_hold;
  logic [1:0] state;

  modport master (
    output key_start_n, key_lap_n, key_clr_n,
    input  count_en, count_clr, lap_load, disp_hold, state
  );

  modport slave (
    input  key_start_n, key_lap_n, key_clr_n,
    output count_en, count_clr, lap_load, disp_hold, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/stop/lap/clear sequencer: three synchronised, debounced
// active-low keys feed one-cycle press events into a 4-state FSM.
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  stopwatch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_LAP  = 2'b10,
    ST_STOP = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int K_START = 0;
  localparam int K_LAP   = 1;
  localparam int K_CLR   = 2;

  logic [2:0]       w_key_raw;
  logic [2:0]       r_sync1;
  logic [2:0]       r_sync2;
  logic [2:0]       r_deb;
  logic [2:0]       r_deb_d;
  logic [2:0]       r_ev;
  logic [CNT_W-1:0] r_cnt [3];

  state_e r_state;
  state_e w_state_nxt;
  logic   w_clr_nxt;
  logic   w_lap_nxt;
  logic   r_count_clr;
  logic   r_lap_load;

  assign w_key_raw = {bus.key_clr_n, bus.key_lap_n, bus.key_start_n};

  // Key front end: synchroniser, debounce counter, press-edge pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 3'b111;
      r_sync2 <= 3'b111;
      r_deb   <= 3'b111;
      r_deb_d <= 3'b111;
      r_ev    <= 3'b000;
      for (int k = 0; k < 3; k++) begin
        r_cnt[k] <= '0;
      end
    end else begin
      r_sync1 <= w_key_raw;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      // Only released->pressed produces an event; release is silent.
      r_ev    <= r_deb_d & ~r_deb;
      for (int k = 0; k < 3; k++) begin
        if (r_sync2[k] == r_deb[k]) begin
          r_cnt[k] <= '0;
        end else if (r_cnt[k] == DB_LAST) begin
          r_deb[k] <= r_sync2[k];
          r_cnt[k] <= '0;
        end else begin
          r_cnt[k] <= r_cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  // Next-state and pulse decode; priority clr > start > lap among events
  // that are meaningful in the current state.
  always_comb begin
    w_state_nxt = r_state;
    w_clr_nxt   = 1'b0;
    w_lap_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_ev[K_CLR]) begin
          w_clr_nxt = 1'b1;
        end else if (r_ev[K_START]) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (r_ev[K_START]) begin
          w_state_nxt = ST_STOP;
        end else if (r_ev[K_LAP]) begin
          w_state_nxt = ST_LAP;
          w_lap_nxt   = 1'b1;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_LAP: begin
        if (r_ev[K_START]) begin
          w_state_nxt = ST_STOP;
        end else if (r_ev[K_LAP]) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_LAP;
        end
      end
      ST_STOP: begin
        if (r_ev[K_CLR]) begin
          w_state_nxt = ST_IDLE;
          w_clr_nxt   = 1'b1;
        end else if (r_ev[K_START]) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_STOP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and pulse registers; pulses coincide with the new state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_count_clr <= 1'b0;
      r_lap_load  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_count_clr <= w_clr_nxt;
      r_lap_load  <= w_lap_nxt;
    end
  end

  assign bus.count_en  = (r_state == ST_RUN) || (r_state == ST_LAP);
  assign bus.disp_hold = (r_state == ST_LAP);
  assign bus.count_clr = r_count_clr;
  assign bus.lap_load  = r_lap_load;
  assign bus.state     = r_state;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Run/stop/lap/clear sequencer for the stopwatch time counter and its display path.
- Takes three raw active-low push buttons and debounces each one.
- Converts each press into a single one-cycle event and runs a 4-state FSM.
- Drives count-enable, count-clear, lap-latch and display-hold controls for the counter and display blocks.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a key level is accepted (10 ms at 50 MHz); minimum 2
CNT_W, 20, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
key_start_n  input  1  raw start/stop button, 0 = pressed, asynchronous to clk
key_lap_n  input  1  raw lap button, 0 = pressed
key_clr_n  input  1  raw clear button, 0 = pressed
count_en  output  1  level, time counter advances while 1
count_clr  output  1  one-cycle pulse, zeroes the time counter
lap_load  output  1  one-cycle pulse, latches the current time into the lap register
disp_hold  output  1  level, display shows the lap register instead of the live count
state  output  2  FSM state: 00 IDLE, 01 RUN, 10 LAP, 11 STOP

Behaviour:
- Reset (asynchronous, any time including mid-press or mid-run):
  - FSM goes to IDLE.
  - All outputs go to 0.
  - Sync flops preset to 1 (released); debounced levels = released; debounce counters = 0.
- Per-key front end (three identical instances):
  - 2-flop synchronizer.
  - Debounce counter clears whenever the synced level equals the debounced level.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level takes the synced value and the counter clears.
  - Press event: a one-cycle registered pulse on the debounced released->pressed transition. Release generates no event.
- Press latency: for a clean press first sampled low at edge N, the event is high during the cycle after edge N+2+DEBOUNCE_CYCLES.
- Bounces: any bounce shorter than DEBOUNCE_CYCLES produces no event.
- Holding a key: produces exactly one event per press.
- Key held through reset release: produces one event after debounce. This is intended.
- Event priority per cycle: clr > start > lap. Only the highest-priority valid event in the current state is consumed; the others are dropped, not queued.
- FSM transitions (ev = event):
  - IDLE: start -> RUN. clr -> stay IDLE, pulse count_clr. lap ignored.
  - RUN: start -> STOP. lap -> LAP, pulse lap_load. clr ignored.
  - LAP: lap -> RUN (display released). start -> STOP (display released). clr ignored.
  - STOP: start -> RUN. clr -> IDLE, pulse count_clr. lap ignored.
- A start+lap coincidence in RUN selects start. An ignored higher-priority event does not block a lower-priority valid one (clr+lap in RUN -> LAP).
- Outputs:
  - State register updates at the edge following the event cycle.
  - count_en = (state==RUN || state==LAP).
  - disp_hold = (state==LAP).
  - Both are decoded from the state register with no extra latency.
  - count_clr and lap_load are registered and high for exactly the one cycle in which the new state first appears.
  - count_clr and lap_load are never both high.
- No other outputs toggle on ignored events.

Test Plan:
- DEBOUNCE_CYCLES=4. Reset, then key_start_n low for 20 cycles -> exactly one start event; state 00->01 and count_en=1 from edge N+7 onward. Release produces no change.
- Bounce: key_start_n toggles every 2 cycles for 12 cycles, then holds low 10 cycles -> exactly one event; a single transition IDLE->RUN.
- RUN, press lap -> lap_load=1 for one cycle, state=10, disp_hold=1, count_en stays 1. Press lap again -> state=01, disp_hold=0, no lap_load.
- RUN, press clr -> no output change. Press start -> STOP, count_en=0. Press clr -> count_clr=1 for one cycle, state=00.
- RUN, start and lap pressed in the same cycle -> state=11, lap_load stays 0. STOP, start+clr together -> count_clr pulse, state=00.
- Mid-LAP, rst_n low for 3 cycles while key_lap_n held low -> all outputs 0 asynchronously, state=00. After reset release, exactly one lap event after debounce, ignored in IDLE.
